// File: rtl/pwm_clock_gen.sv
// Multi-channel PWM clock generator: one shared period counter, per-channel high times,
// double-buffered config swapped at period boundaries; every output comes straight from a flop.
module pwm_clock_gen #(
  parameter int CNT_W = 16,
  parameter int NCH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cfg_wr,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [NCH*CNT_W-1:0] cfg_high,
  output logic [NCH-1:0]     clk_out,
  output logic               period_tick,
  output logic               running
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0]       p_pend, p_act, p_act_nxt, p_wr;
  logic [NCH*CNT_W-1:0]   h_pend, h_act, h_act_nxt;
  logic [NCH-1:0]         clk_nxt;
  logic                   wrap;
  logic                   tick_nxt;

  // A zero period would make a 1-cycle clock; clamp to the 2-cycle minimum.
  assign p_wr = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
  assign wrap = (state != IDLE) && (cnt == p_act);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    p_act_nxt = p_act;
    h_act_nxt = h_act;
    unique case (state)
      IDLE: begin
        cnt_nxt   = '0;
        p_act_nxt = p_pend;
        h_act_nxt = h_pend;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (wrap) begin
          cnt_nxt   = '0;
          p_act_nxt = p_pend;
          h_act_nxt = h_pend;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (!enable) state_nxt = wrap ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (wrap) begin
          cnt_nxt   = '0;
          p_act_nxt = p_pend;
          h_act_nxt = h_pend;
          state_nxt = enable ? RUN : IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so the registered copies line up with cnt.
  always_comb begin
    clk_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      clk_nxt[i] = (state_nxt != IDLE) && (cnt_nxt < h_act_nxt[i*CNT_W +: CNT_W]);
    end
    tick_nxt = (state_nxt != IDLE) && (cnt_nxt == p_act_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      p_pend      <= CNT_W'(1);
      p_act       <= CNT_W'(1);
      h_pend      <= '0;
      h_act       <= '0;
      clk_out     <= '0;
      period_tick <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      p_act       <= p_act_nxt;
      h_act       <= h_act_nxt;
      clk_out     <= clk_nxt;
      period_tick <= tick_nxt;
      running     <= (state_nxt != IDLE);
      if (cfg_wr) begin
        p_pend <= p_wr;
        h_pend <= cfg_high;
      end
    end
  end

endmodule

// File: tb/tb_pwm_clock_gen.sv
// Bench for pwm_clock_gen with CNT_W=8, NCH=2: table of single-cycle vectors plus period-level sequences.
module tb_pwm_clock_gen;

  localparam int CNT_W = 8;
  localparam int NCH   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               cfg_wr = 1'b0;
  logic [CNT_W-1:0]   cfg_period = '0;
  logic [NCH*CNT_W-1:0] cfg_high = '0;
  logic [NCH-1:0]     clk_out;
  logic               period_tick;
  logic               running;

  int n_checks = 0;
  int n_fails  = 0;

  pwm_clock_gen #(.CNT_W(CNT_W), .NCH(NCH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_wr      (cfg_wr),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .running     (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        wr;
    logic [7:0]  per;
    logic [15:0] high;
    logic [1:0]  e_clk;
    logic        e_tick;
    logic        e_run;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic w, input logic [7:0] p,
                     input logic [15:0] h, input logic [1:0] ec, input logic et,
                     input logic er, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.per = p; v.high = h;
    v.e_clk = ec; v.e_tick = et; v.e_run = er; v.name = nm;
    vq.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] ec, input logic et, input logic er);
    n_checks++;
    if (clk_out !== ec) begin
      n_fails++;
      $display("FAIL %s clk_out: got %b expected %b", nm, clk_out, ec);
    end
    n_checks++;
    if (period_tick !== et) begin
      n_fails++;
      $display("FAIL %s period_tick: got %b expected %b", nm, period_tick, et);
    end
    n_checks++;
    if (running !== er) begin
      n_fails++;
      $display("FAIL %s running: got %b expected %b", nm, running, er);
    end
  endtask

  // One period of P+1 cycles with H={h1,h0}; optional config write, enable drop/raise, early stop.
  task automatic run_period(input string nm, input int p, input int h0, input int h1,
                            input int wr_at, input int wr_p, input int wr_h0, input int wr_h1,
                            input int drop_at, input int raise_at, input int stop_at);
    logic [1:0] ec;
    logic [7:0] b0, b1;
    for (int k = 0; k <= p; k++) begin
      cyc();
      cfg_wr = 1'b0;
      ec[0] = (k < h0);
      ec[1] = (k < h1);
      chk($sformatf("%s_cnt%0d", nm, k), ec, (k == p), 1'b1);
      if (k == stop_at) return;
      if (k == wr_at) begin
        b0 = wr_h0[7:0];
        b1 = wr_h1[7:0];
        cfg_wr     = 1'b1;
        cfg_period = wr_p[7:0];
        cfg_high   = {b1, b0};
      end
      if (k == drop_at)  enable = 1'b0;
      if (k == raise_at) enable = 1'b1;
    end
  endtask

  initial begin
    // Reset, P=0 clamp with H={ch1=1,ch0=0}, drain, and rst beating cfg_wr/enable.
    add(1, 0, 0, 8'd0, 16'h0000, 2'b00, 0, 0, "reset");
    add(0, 0, 1, 8'd0, 16'h0100, 2'b00, 0, 0, "idle_cfg");
    add(0, 1, 0, 8'd0, 16'h0000, 2'b10, 0, 1, "p2_c0a");
    add(0, 1, 0, 8'd0, 16'h0000, 2'b00, 1, 1, "p2_c1a");
    add(0, 1, 0, 8'd0, 16'h0000, 2'b10, 0, 1, "p2_c0b");
    add(0, 1, 0, 8'd0, 16'h0000, 2'b00, 1, 1, "p2_c1b");
    add(0, 1, 0, 8'd0, 16'h0000, 2'b10, 0, 1, "p2_c0c");
    add(0, 0, 0, 8'd0, 16'h0000, 2'b00, 1, 1, "p2_drain");
    add(0, 0, 0, 8'd0, 16'h0000, 2'b00, 0, 0, "p2_idle");
    add(0, 0, 0, 8'd0, 16'h0000, 2'b00, 0, 0, "stay_idle");
    add(1, 1, 1, 8'd5, 16'h0303, 2'b00, 0, 0, "rst_prio");
    add(0, 1, 0, 8'd0, 16'h0000, 2'b00, 0, 1, "dflt_c0");
    add(0, 1, 0, 8'd0, 16'h0000, 2'b00, 1, 1, "dflt_c1");
    add(0, 1, 0, 8'd0, 16'h0000, 2'b00, 0, 1, "dflt_c0b");
    add(0, 0, 0, 8'd0, 16'h0000, 2'b00, 1, 1, "dflt_drain");
    add(0, 0, 0, 8'd0, 16'h0000, 2'b00, 0, 0, "dflt_idle");

    #1;
    foreach (vq[i]) begin
      rst        = vq[i].rst;
      enable     = vq[i].en;
      cfg_wr     = vq[i].wr;
      cfg_period = vq[i].per;
      cfg_high   = vq[i].high;
      cyc();
      chk(vq[i].name, vq[i].e_clk, vq[i].e_tick, vq[i].e_run);
    end
    cfg_wr = 1'b0;

    // Basic P=9, H={5,2}
    rst = 1'b1; cyc(); rst = 1'b0;
    cfg_wr = 1'b1; cfg_period = 8'd9; cfg_high = 16'h0205;
    cyc(); cfg_wr = 1'b0;
    chk("cfg_idle", 2'b00, 1'b0, 1'b0);
    enable = 1'b1;
    run_period("p9a", 9, 5, 2, -1, 0, 0, 0, -1, -1, -1);
    // Mid-period rewrite: current period finishes at 10 cycles
    run_period("p9b", 9, 5, 2, 3, 3, 2, 4, -1, -1, -1);
    run_period("p3a", 3, 2, 4, -1, 0, 0, 0, -1, -1, -1);
    // Write coincident with the tick lands one full period later
    run_period("p3b", 3, 2, 4, 3, 5, 1, 0, -1, -1, -1);
    run_period("p3c", 3, 2, 4, -1, 0, 0, 0, -1, -1, -1);
    run_period("p5a", 5, 1, 0, 2, 9, 5, 2, -1, -1, -1);
    // Enable dropped at cnt=3: period completes then IDLE
    run_period("drn", 9, 5, 2, -1, 0, 0, 0, 3, -1, -1);
    cyc(); chk("drn_idle0", 2'b00, 1'b0, 1'b0);
    cyc(); chk("drn_idle1", 2'b00, 1'b0, 1'b0);
    enable = 1'b1;
    // Re-enable during drain: no gap
    run_period("ren", 9, 5, 2, -1, 0, 0, 0, 3, 6, -1);
    run_period("ren2", 9, 5, 2, -1, 0, 0, 0, -1, -1, -1);
    // Reset mid-period while ch0 high
    run_period("pre_rst", 9, 5, 2, -1, 0, 0, 0, -1, -1, 4);
    rst = 1'b1;
    cyc(); chk("rst_mid", 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(); chk("post_rst_c0", 2'b00, 1'b0, 1'b1);
    cyc(); chk("post_rst_c1", 2'b00, 1'b1, 1'b1);
    cyc(); chk("post_rst_c0b", 2'b00, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pwm_clock_gen.md
PWM_CLOCK_GEN -- requirements
Module: pwm_clock_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of the period and high-time counters.
REQ-002 Parameter NCH, default 2, number of independent clock output channels.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  level request to run the generator.
REQ-006 cfg_wr  input  1  single-cycle strobe capturing cfg_period and cfg_high into the pending registers.
REQ-007 cfg_period  input  CNT_W  period minus one, in clk cycles (P; period = P+1 cycles).
REQ-008 cfg_high  input  NCH*CNT_W  per-channel high time in cycles; channel i at bits [i*CNT_W +: CNT_W].
REQ-009 clk_out  output  NCH  generated clocks, one bit per channel, driven directly from flops.
REQ-010 period_tick  output  1  one-cycle pulse on the last cycle of each period.
REQ-011 running  output  1  high in states RUN and DRAIN.

Function
REQ-012 The block SHALL hold a pending config (period, NCH high times) and an active config; counting and outputs SHALL use the active config only.
REQ-013 cfg_wr SHALL overwrite the pending config in any state; multiple writes within one period: last write wins.
REQ-014 A cfg_period value of 0 SHALL be stored as 1 (minimum period 2 cycles).
REQ-015 States: IDLE, RUN, DRAIN; a single CNT_W-bit counter cnt counts 0..P_act.
REQ-016 IDLE: cnt=0, clk_out=0, period_tick=0, running=0; the active config SHALL be copied from pending every IDLE cycle.
REQ-017 IDLE with enable=1 -> RUN on next edge; first RUN cycle has cnt=0.
REQ-018 RUN/DRAIN: cnt increments each cycle; when cnt==P_act, period_tick=1 that cycle and cnt wraps to 0 next cycle.
REQ-019 At each wrap edge the active config SHALL load from pending; a cfg_wr in the same cycle as period_tick takes effect at the following wrap, not this one.
REQ-020 In RUN/DRAIN, clk_out[i]=1 exactly in cycles where cnt < H_act[i]; clk_out SHALL be computed from next-state values and registered so no combinational path drives it.
REQ-021 H_act[i]=0 SHALL give constant 0; H_act[i] >= P_act+1 SHALL give constant 1 for the whole period.
REQ-022 RUN with enable=0 -> DRAIN; the current period SHALL complete unchanged (no truncated high pulse).
REQ-023 DRAIN with period_tick -> IDLE if enable=0, else RUN; enable re-asserted during DRAIN SHALL cause no interruption or phase change.
REQ-024 All channels SHALL share cnt, so rising edges of all channels with H>0 align to cnt=0.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, cnt=0, clk_out=0, period_tick=0, running=0, pending/active period=1, all high times=0, regardless of state or other inputs.
REQ-026 rst SHALL take priority over enable and cfg_wr in the same cycle; mid-period reset SHALL truncate immediately.
REQ-027 After rst deasserts, the block SHALL leave IDLE only on a cycle with enable=1.

Verification
REQ-028 CNT_W=8, NCH=2: cfg P=9, H={5,2}, enable=1 -> period 10 cycles; ch0 high 5, ch1 high 2; period_tick every 10th cycle.
REQ-029 While running P=9, cfg_wr P=3, H={2,4} mid-period -> current period finishes at 10 cycles, next period 4 cycles, ch0 2 high, ch1 constant 1.
REQ-030 enable dropped at cnt=3 with P=9 -> running stays 1 until cnt=9 tick, then IDLE, clk_out=0; re-enable at cnt=6 instead -> continuous output, no gap.
REQ-031 cfg P=0, H={0,1} -> period 2 cycles, ch0 constant 0, ch1 50% duty.
REQ-032 rst pulsed at cnt=4 while ch0 high -> next cycle clk_out=0, running=0, state IDLE; enable still 1 -> RUN one cycle after rst deasserts with period 2, outputs 0.
REQ-033 cfg_wr coincident with period_tick -> new values appear one full period later; cfg_wr coincident with rst -> discarded.
